iterative_shifter: RTL and testbench



---
 rtl/iterative_shifter.sv | 138 +++++++++++++
 tb/tb_iterative_shifter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// ============================================================================
// Module   : iterative_shifter
// Summary  : Multi-cycle rotator/shifter that applies one log-step stage per
//            cycle, with valid/ready handshakes on both sides.
//            Optional macro SHIFTER_EARLY_EXIT_EN finishes as soon as no
//            higher shamt bits remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module iterative_shifter #(
  parameter int DATA     = 8,
  parameter int SHAMT    = 3,
  parameter bit ROTATE   = `Enable,
  parameter bit TO_RIGHT = `Enable,
  parameter bit ARITH    = `Disable
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA-1:0]  in,
  input  logic [SHAMT-1:0] shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA-1:0]  out,
  output logic             busy
);

  localparam int STEP_W    = (SHAMT > 1) ? $clog2(SHAMT) : 1;
  localparam bit USE_ARITH = ARITH && !ROTATE && TO_RIGHT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA-1:0]   data_q,  data_d;
  logic [DATA-1:0]   out_q,   out_d;
  logic [SHAMT-1:0]  shamt_q, shamt_d;
  logic [STEP_W-1:0] step_q,  step_d;

  logic [DATA-1:0]   w_stage [SHAMT];
  logic [DATA-1:0]   w_apply;
  logic              w_fill;
  logic              w_last;

  assign w_fill = USE_ARITH & data_q[DATA-1];

  // Each stage has a constant amount 2^j kept at full width, so stages whose
  // amount reaches DATA become all-fill for shifts and wrap modulo DATA for rotates.
  generate
    for (genvar j = 0; j < SHAMT; j++) begin : g_stage
      localparam longint unsigned AMT = 64'd1 << j;
      localparam int ROT = int'(AMT % 64'(DATA));
      localparam int SH  = (AMT >= 64'(DATA)) ? DATA : int'(AMT);
      localparam logic [DATA-1:0] HI = ~({DATA{1'b1}} >> SH);
      logic [DATA-1:0] w_rot;
      logic [DATA-1:0] w_shf;
      assign w_rot = TO_RIGHT ? ((data_q >> ROT) | (data_q << (DATA - ROT)))
                              : ((data_q << ROT) | (data_q >> (DATA - ROT)));
      assign w_shf = TO_RIGHT ? ((data_q >> SH) | (HI & {DATA{w_fill}}))
                              : (data_q << SH);
      assign w_stage[j] = ROTATE ? w_rot : w_shf;
    end
  endgenerate

  assign w_apply = shamt_q[step_q] ? w_stage[step_q] : data_q;

`ifdef SHIFTER_EARLY_EXIT_EN
  assign w_last = ((shamt_q >> step_q) >> 1) == '0;
`else
  assign w_last = (step_q == STEP_W'(SHAMT - 1));
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    out_d   = out_q;
    shamt_d = shamt_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in;
          shamt_d = shamt;
          step_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = w_apply;
        step_d = step_q + 1'b1;
        if (w_last) begin
          out_d   = w_apply;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      out_q   <= '0;
      shamt_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
      shamt_q <= shamt_d;
      step_q  <= step_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// ============================================================================
// Module   : tb_iterative_shifter
// Summary  : Scoreboard bench driving four shifter flavours in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_shifter;

  logic       clk = 1'b0;
  logic       reset_;
  logic       in_valid;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       out_ready;

  logic       in_ready  [4];
  logic       out_valid [4];
  logic       busy      [4];
  logic [7:0] dout      [4];

  logic [31:0] sb_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // index 0: rotate right, 1: logical right, 2: arithmetic right, 3: logical left
  iterative_shifter #(.DATA(8), .SHAMT(3)) u_rot (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in(din), .shamt(shamt), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out(dout[0]), .busy(busy[0]));
  iterative_shifter #(.DATA(8), .SHAMT(3), .ROTATE(1'b0)) u_lsr (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in(din), .shamt(shamt), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out(dout[1]), .busy(busy[1]));
  iterative_shifter #(.DATA(8), .SHAMT(3), .ROTATE(1'b0), .ARITH(1'b1)) u_asr (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in(din), .shamt(shamt), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out(dout[2]), .busy(busy[2]));
  iterative_shifter #(.DATA(8), .SHAMT(3), .ROTATE(1'b0), .TO_RIGHT(1'b0)) u_lsl (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready[3]),
    .in(din), .shamt(shamt), .out_valid(out_valid[3]), .out_ready(out_ready),
    .out(dout[3]), .busy(busy[3]));

  // Reference: k single-bit moves, independent of the log-step decomposition.
  function automatic logic [7:0] model(input logic [7:0] d, input int k, input int mode);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < k; i++) begin
      case (mode)
        0:       r = {r[0], r[7:1]};
        1:       r = {1'b0, r[7:1]};
        2:       r = {r[7], r[7:1]};
        default: r = {r[6:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] s);
`ifdef SHIFTER_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < 3; i++) if (s[i]) l = i + 1;
    return l;
`else
    return 3;
`endif
  endfunction

  // Drives one request, pushes its expectation, waits (bounded) for out_valid.
  task automatic send(input logic [7:0] d, input logic [2:0] s,
                      output int lat, output int rdy_seen);
    logic [31:0] e;
    @(negedge clk);
    in_valid = 1'b1; din = d; shamt = s;
    for (int m = 0; m < 4; m++) e[m*8 +: 8] = model(d, s, m);
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; din = ~d; shamt = ~s;
    lat = 0; rdy_seen = 0;
    if (in_ready[0]) rdy_seen++;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready[0] && !out_valid[0]) rdy_seen++;
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0; in_valid = 1'b0; din = '0; shamt = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (in_ready[m] !== 1'b1)  begin n_bad++; $display("FAIL reset in_ready[%0d] got %b want 1", m, in_ready[m]); end
      n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL reset out_valid[%0d] got %b want 0", m, out_valid[m]); end
      n_cmp++; if (busy[m] !== 1'b0)      begin n_bad++; $display("FAIL reset busy[%0d] got %b want 0", m, busy[m]); end
      n_cmp++; if (dout[m] !== 8'h00)     begin n_bad++; $display("FAIL reset out[%0d] got %h want 00", m, dout[m]); end
    end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_basic();
    int lat, rdy;
    logic [31:0] e;
    logic [31:0] fixed;
    fixed = {8'hE0, 8'hF3, 8'h13, 8'h93};
    out_ready = 1'b1;
    send(8'b10011100, 3'd3, lat, rdy);
    n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL basic timeout out_valid got %b want 1", out_valid[0]); end
    n_cmp++; if (lat !== exp_lat(3'd3)) begin n_bad++; $display("FAIL basic latency got %0d want %0d", lat, exp_lat(3'd3)); end
    n_cmp++; if (rdy !== 0) begin n_bad++; $display("FAIL basic in_ready_while_busy got %0d want 0", rdy); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic busy_in_done got %b want 1", busy[0]); end
    e = sb_q.pop_front();
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (dout[m] !== e[m*8 +: 8])     begin n_bad++; $display("FAIL basic out[%0d] got %h want %h", m, dout[m], e[m*8 +: 8]); end
      n_cmp++; if (dout[m] !== fixed[m*8 +: 8]) begin n_bad++; $display("FAIL basic_const out[%0d] got %h want %h", m, dout[m], fixed[m*8 +: 8]); end
    end
    @(posedge clk); #1;
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL basic ready_after got %b want 1", in_ready[0]); end
  endtask

  task automatic test_sweep();
    int lat, rdy;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      send(8'b10011100, 3'(s), lat, rdy);
      n_cmp++; if (lat !== exp_lat(3'(s))) begin n_bad++; $display("FAIL sweep latency shamt=%0d got %0d want %0d", s, lat, exp_lat(3'(s))); end
      e = sb_q.pop_front();
      for (int m = 0; m < 4; m++) begin
        n_cmp++; if (dout[m] !== e[m*8 +: 8]) begin n_bad++; $display("FAIL sweep shamt=%0d out[%0d] got %h want %h", s, m, dout[m], e[m*8 +: 8]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat, rdy;
    logic [31:0] e;
    logic [7:0] held;
    out_ready = 1'b0;
    send(8'hC3, 3'd5, lat, rdy);
    e = sb_q.pop_front();
    held = e[7:0];
    n_cmp++; if (dout[0] !== held) begin n_bad++; $display("FAIL bp out got %h want %h", dout[0], held); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = ~in_valid; din = 8'($urandom); shamt = 3'($urandom);
      @(posedge clk); #1;
      n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bp hold out_valid got %b want 1", out_valid[0]); end
      n_cmp++; if (dout[0] !== held)      begin n_bad++; $display("FAIL bp hold out got %h want %h", dout[0], held); end
      n_cmp++; if (in_ready[0] !== 1'b0)  begin n_bad++; $display("FAIL bp hold in_ready got %b want 0", in_ready[0]); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready[0] !== 1'b1)  begin n_bad++; $display("FAIL bp release in_ready got %b want 1", in_ready[0]); end
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp release out_valid got %b want 0", out_valid[0]); end
    n_cmp++; if (dout[0] !== held)      begin n_bad++; $display("FAIL bp release out got %h want %h", dout[0], held); end
  endtask

  task automatic test_reset_mid();
    int lat, rdy;
    logic [31:0] e;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; din = 8'h5A; shamt = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid busy_before got %b want 1", busy[0]); end
    reset_ = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (out_valid[m] !== 1'b0) begin n_bad++; $display("FAIL rstmid out_valid[%0d] got %b want 0", m, out_valid[m]); end
      n_cmp++; if (in_ready[m] !== 1'b1)  begin n_bad++; $display("FAIL rstmid in_ready[%0d] got %b want 1", m, in_ready[m]); end
      n_cmp++; if (busy[m] !== 1'b0)      begin n_bad++; $display("FAIL rstmid busy[%0d] got %b want 0", m, busy[m]); end
      n_cmp++; if (dout[m] !== 8'h00)     begin n_bad++; $display("FAIL rstmid out[%0d] got %h want 00", m, dout[m]); end
    end
    @(negedge clk);
    reset_ = 1'b1;
    send(8'hA5, 3'd6, lat, rdy);
    n_cmp++; if (lat !== exp_lat(3'd6)) begin n_bad++; $display("FAIL rstmid latency got %0d want %0d", lat, exp_lat(3'd6)); end
    e = sb_q.pop_front();
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (dout[m] !== e[m*8 +: 8]) begin n_bad++; $display("FAIL rstmid after out[%0d] got %h want %h", m, dout[m], e[m*8 +: 8]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, rdy;
    logic [31:0] e;
    logic [7:0] d;
    logic [2:0] s;
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      d = 8'($urandom);
      s = 3'($urandom);
      send(d, s, lat, rdy);
      n_cmp++; if (lat !== exp_lat(s)) begin n_bad++; $display("FAIL b2b latency shamt=%0d got %0d want %0d", s, lat, exp_lat(s)); end
      e = sb_q.pop_front();
      for (int m = 0; m < 4; m++) begin
        n_cmp++; if (dout[m] !== e[m*8 +: 8]) begin n_bad++; $display("FAIL b2b in=%h shamt=%0d out[%0d] got %h want %h", d, s, m, dout[m], e[m*8 +: 8]); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
